// File: rtl/pe_sequencer.sv
// Expands one vector instruction into ceil(vl/LANES) PE beats, pausing for a ripple response
// between beats when required. Optional perf counters are enabled by PE_SEQ_PERF_CNT_EN.
module pe_sequencer #(
  parameter int unsigned LANES = 4,
  parameter int unsigned VL_W  = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [3:0]       instr_op_i,
  input  logic [1:0]       instr_operand_i,
  input  logic [1:0]       instr_sat_i,
  input  logic [1:0]       instr_mode_i,
  input  logic [VL_W-1:0]  instr_vl_i,
  output logic             pe_valid_o,
  input  logic             pe_ready_i,
  output logic [3:0]       pe_op_o,
  output logic [1:0]       pe_operand_o,
  output logic [1:0]       pe_sat_o,
  output logic [1:0]       pe_mode_o,
  output logic [VL_W-1:0]  pe_beat_o,
  output logic [LANES-1:0] pe_lane_en_o,
  output logic             pe_last_o,
  input  logic             pe_resp_i,
  output logic             busy_o,
  output logic             done_o
`ifdef PE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_o,
  output logic [31:0]      perf_beats_o
`endif
);

  localparam int unsigned LaneW           = $clog2(LANES);
  localparam logic [1:0]  PeOperandRipple = 2'd3;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRipple, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q;
  logic [1:0]        operand_q, sat_q, mode_q;
  logic [VL_W-1:0]   vl_q, beat_q, beat_d;
  logic              last_sent_q, last_sent_d;
  logic              accept, is_last, is_ripple;
  logic [VL_W-1:0]   last_beat;
  logic [LaneW-1:0]  rem;

  // Index of the final beat; only meaningful once a non-zero vl is latched.
  assign last_beat = (vl_q - VL_W'(1)) >> LaneW;
  assign rem       = vl_q[LaneW-1:0];
  assign is_last   = (beat_q == last_beat);
  assign is_ripple = (operand_q == PeOperandRipple);

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    last_sent_d   = last_sent_q;
    accept        = 1'b0;
    instr_ready_o = 1'b0;
    pe_valid_o    = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    pe_op_o       = '0;
    pe_operand_o  = '0;
    pe_sat_o      = '0;
    pe_mode_o     = '0;
    pe_beat_o     = '0;
    pe_lane_en_o  = '0;
    pe_last_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          accept      = 1'b1;
          beat_d      = '0;
          last_sent_d = 1'b0;
          state_d     = (instr_vl_i == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        busy_o       = 1'b1;
        pe_valid_o   = 1'b1;
        pe_op_o      = op_q;
        pe_operand_o = operand_q;
        pe_sat_o     = sat_q;
        pe_mode_o    = mode_q;
        pe_beat_o    = beat_q;
        pe_last_o    = is_last;
        for (int unsigned i = 0; i < LANES; i++) begin
          pe_lane_en_o[i] = !is_last || (rem == '0) || (LaneW'(i) < rem);
        end
        if (pe_ready_i) begin
          if (is_last) begin
            last_sent_d = 1'b1;
            state_d     = is_ripple ? StWaitRipple : StDone;
          end else begin
            beat_d  = beat_q + VL_W'(1);
            state_d = is_ripple ? StWaitRipple : StIssue;
          end
        end
      end
      StWaitRipple: begin
        busy_o = 1'b1;
        if (pe_resp_i) begin
          state_d = last_sent_q ? StDone : StIssue;
        end
      end
      StDone: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      last_sent_q <= 1'b0;
      op_q        <= '0;
      operand_q   <= '0;
      sat_q       <= '0;
      mode_q      <= '0;
      vl_q        <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_sent_q <= last_sent_d;
      if (accept) begin
        op_q      <= instr_op_i;
        operand_q <= instr_operand_i;
        sat_q     <= instr_sat_i;
        mode_q    <= instr_mode_i;
        vl_q      <= instr_vl_i;
      end
    end
  end

`ifdef PE_SEQ_PERF_CNT_EN
  logic        beat_fire;
  logic [31:0] stall_q, beats_q;

  assign beat_fire = pe_valid_o & pe_ready_i;

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      if (pe_valid_o && !pe_ready_i && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (beat_fire && (beats_q != '1)) beats_q <= beats_q + 32'd1;
    end
  end

  assign perf_stall_o = stall_q;
  assign perf_beats_o = beats_q;
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// Scoreboard bench for pe_sequencer: expected beats are queued when an instruction is driven
// and compared as the PE side accepts them; scenario tasks check timing and status inline.
module tb_pe_sequencer;

  localparam int unsigned LANES = 4;
  localparam int unsigned VL_W  = 8;

  logic             clk;
  logic             n_reset;
  logic             instr_valid;
  logic             instr_ready;
  logic [3:0]       instr_op;
  logic [1:0]       instr_operand;
  logic [1:0]       instr_sat;
  logic [1:0]       instr_mode;
  logic [VL_W-1:0]  instr_vl;
  logic             pe_valid;
  logic             pe_ready;
  logic [3:0]       pe_op;
  logic [1:0]       pe_operand;
  logic [1:0]       pe_sat;
  logic [1:0]       pe_mode;
  logic [VL_W-1:0]  pe_beat;
  logic [LANES-1:0] pe_lane_en;
  logic             pe_last;
  logic             pe_resp;
  logic             busy;
  logic             done;
`ifdef PE_SEQ_PERF_CNT_EN
  logic [31:0]      perf_stall;
  logic [31:0]      perf_beats;
`endif

  pe_sequencer #(
    .LANES (LANES),
    .VL_W  (VL_W)
  ) dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .instr_valid_i   (instr_valid),
    .instr_ready_o   (instr_ready),
    .instr_op_i      (instr_op),
    .instr_operand_i (instr_operand),
    .instr_sat_i     (instr_sat),
    .instr_mode_i    (instr_mode),
    .instr_vl_i      (instr_vl),
    .pe_valid_o      (pe_valid),
    .pe_ready_i      (pe_ready),
    .pe_op_o         (pe_op),
    .pe_operand_o    (pe_operand),
    .pe_sat_o        (pe_sat),
    .pe_mode_o       (pe_mode),
    .pe_beat_o       (pe_beat),
    .pe_lane_en_o    (pe_lane_en),
    .pe_last_o       (pe_last),
    .pe_resp_i       (pe_resp),
    .busy_o          (busy),
    .done_o          (done)
`ifdef PE_SEQ_PERF_CNT_EN
    ,
    .perf_stall_o    (perf_stall),
    .perf_beats_o    (perf_beats)
`endif
  );

  typedef struct packed {
    logic [VL_W-1:0]  beat;
    logic [LANES-1:0] lane_en;
    logic             last;
    logic [3:0]       op;
    logic [1:0]       operand;
    logic [1:0]       sat;
    logic [1:0]       mode;
  } beat_t;

  beat_t sb[$];
  beat_t exp_b, got_b;
  int    n_checks = 0;
  int    n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  // Beat-level scoreboard on the falling edge, plus zero-field check while idle.
  always @(negedge clk) begin
    got_b = {pe_beat, pe_lane_en, pe_last, pe_op, pe_operand, pe_sat, pe_mode};
    if (n_reset && pe_valid && pe_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got beat %0d lane_en %b, required no beat", pe_beat,
                 pe_lane_en);
      end else begin
        exp_b = sb.pop_front();
        if (got_b !== exp_b) begin
          n_fail++;
          $display("FAIL beat_fields: got beat %0d lane %b last %b op %h opd %0d sat %0d mode %0d, required beat %0d lane %b last %b op %h opd %0d sat %0d mode %0d",
                   got_b.beat, got_b.lane_en, got_b.last, got_b.op, got_b.operand, got_b.sat,
                   got_b.mode, exp_b.beat, exp_b.lane_en, exp_b.last, exp_b.op, exp_b.operand,
                   exp_b.sat, exp_b.mode);
        end
      end
    end else if (pe_valid !== 1'b1) begin
      n_checks++;
      if (got_b !== '0) begin
        n_fail++;
        $display("FAIL idle_fields_zero: got %h, required 0", got_b);
      end
    end
  end

  task automatic push_expected(input logic [3:0] op, input logic [1:0] operand,
                               input logic [1:0] sat, input logic [1:0] mode, input int vl);
    int    nb;
    int    rem;
    beat_t e;
    nb = (vl + LANES - 1) / LANES;
    for (int b = 0; b < nb; b++) begin
      rem       = vl - b * LANES;
      e.beat    = VL_W'(b);
      e.lane_en = '0;
      for (int i = 0; i < LANES; i++) if (i < rem) e.lane_en[i] = 1'b1;
      e.last    = (b == nb - 1);
      e.op      = op;
      e.operand = operand;
      e.sat     = sat;
      e.mode    = mode;
      sb.push_back(e);
    end
  endtask

  // Offers one instruction; returns 1ns after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [1:0] operand, input logic [1:0] sat,
                       input logic [1:0] mode, input logic [VL_W-1:0] vl);
    instr_op      = op;
    instr_operand = operand;
    instr_sat     = sat;
    instr_mode    = mode;
    instr_vl      = vl;
    instr_valid   = 1'b1;
    @(negedge clk);
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: got instr_ready %b, required 1", instr_ready);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({instr_ready, pe_valid, busy, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_status: got ready/valid/busy/done %b, required 1000",
               {instr_ready, pe_valid, busy, done});
    end
  endtask

  task automatic test_vs1_beats();
    int n;
    pe_ready = 1'b1;
    push_expected(4'h5, 2'd0, 2'd1, 2'd2, 10);
    issue(4'h5, 2'd0, 2'd1, 2'd2, 8'd10);
    n_checks++;
    if (pe_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_beat_latency: got pe_valid %b, required 1", pe_valid);
    end
    // A second offer while busy must not disturb the running instruction.
    instr_op    = 4'hA;
    instr_vl    = 8'd7;
    instr_valid = 1'b1;
    wait_done(n);
    instr_valid = 1'b0;
    n_checks++;
    if (n != 3) begin
      n_fail++;
      $display("FAIL vs1_done_latency: got %0d cycles, required 3", n);
    end
    n_checks++;
    if ({busy, instr_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL done_cycle_status: got busy/ready %b, required 10", {busy, instr_ready});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, busy, instr_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL vs1_back_idle: got done/busy/ready %b, required 001",
               {done, busy, instr_ready});
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL vs1_beats_left: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_ripple();
    pe_ready = 1'b1;
    push_expected(4'h3, 2'd3, 2'd0, 2'd1, 8);
    issue(4'h3, 2'd3, 2'd0, 2'd1, 8'd8);
    for (int b = 0; b < 2; b++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({pe_valid, busy} !== 2'b01) begin
        n_fail++;
        $display("FAIL ripple_wait: got valid/busy %b, required 01", {pe_valid, busy});
      end
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      pe_resp = 1'b1;
      @(posedge clk);
      #1;
      pe_resp = 1'b0;
      if (b == 0) begin
        n_checks++;
        if ({pe_valid, done} !== 2'b10) begin
          n_fail++;
          $display("FAIL ripple_resume: got valid/done %b, required 10", {pe_valid, done});
        end
      end else begin
        n_checks++;
        if ({pe_valid, done} !== 2'b01) begin
          n_fail++;
          $display("FAIL ripple_done: got valid/done %b, required 01", {pe_valid, done});
        end
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ripple_end: got pending %0d done %b, required 0 0", sb.size(), done);
    end
  endtask

  task automatic test_vl_zero();
    issue(4'h7, 2'd1, 2'd2, 2'd3, 8'd0);
    n_checks++;
    if ({pe_valid, done, instr_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL vl0_done: got valid/done/ready %b, required 010",
               {pe_valid, done, instr_ready});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, instr_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL vl0_idle: got done/ready %b, required 01", {done, instr_ready});
    end
  endtask

  task automatic test_stall();
    logic [22:0] held;
    n_reset = 1'b0;
    #2;
    n_reset  = 1'b1;
    pe_ready = 1'b1;
    push_expected(4'h2, 2'd1, 2'd3, 2'd0, 5);
    issue(4'h2, 2'd1, 2'd3, 2'd0, 8'd5);
    @(posedge clk);
    #1;
    pe_ready = 1'b0;
    pe_resp  = 1'b1;
    held = {pe_beat, pe_lane_en, pe_last, pe_op, pe_operand, pe_sat, pe_mode};
    n_checks++;
    if (held !== {8'd1, 4'b0001, 1'b1, 4'h2, 2'd1, 2'd3, 2'd0}) begin
      n_fail++;
      $display("FAIL stall_beat1: got %h, required beat 1 lane 0001 last", held);
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (pe_valid !== 1'b1 ||
          {pe_beat, pe_lane_en, pe_last, pe_op, pe_operand, pe_sat, pe_mode} !== held) begin
        n_fail++;
        $display("FAIL stall_hold: got valid %b fields %h, required 1 %h", pe_valid,
                 {pe_beat, pe_lane_en, pe_last, pe_op, pe_operand, pe_sat, pe_mode}, held);
      end
    end
    pe_ready = 1'b1;
    pe_resp  = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_done: got done %b, required 1", done);
    end
`ifdef PE_SEQ_PERF_CNT_EN
    n_checks++;
    if (perf_stall !== 32'd4 || perf_beats !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_counts: got stall %0d beats %0d, required 4 2", perf_stall, perf_beats);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int n;
    bit saw_done;
    pe_ready = 1'b1;
    push_expected(4'h1, 2'd0, 2'd0, 2'd0, 12);
    issue(4'h1, 2'd0, 2'd0, 2'd0, 8'd12);
    @(posedge clk);
    #1;
    n_reset = 1'b0;
    #1;
    n_checks++;
    if ({pe_valid, instr_ready, busy, done} !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_reset_status: got valid/ready/busy/done %b, required 0100",
               {pe_valid, instr_ready, busy, done});
    end
    sb.delete();
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_reset = 1'b1;
    if (done === 1'b1) saw_done = 1'b1;
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got done pulse, required none");
    end
    push_expected(4'h4, 2'd2, 2'd1, 2'd1, 4);
    issue(4'h4, 2'd2, 2'd1, 2'd1, 8'd4);
    wait_done(n);
    n_checks++;
    if (n != 1) begin
      n_fail++;
      $display("FAIL post_reset_done: got %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_beats_left: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_vl_max();
    int n;
    pe_ready = 1'b1;
    push_expected(4'h6, 2'd1, 2'd2, 2'd3, 255);
    issue(4'h6, 2'd1, 2'd2, 2'd3, 8'd255);
    wait_done(n);
    n_checks++;
    if (n != 64) begin
      n_fail++;
      $display("FAIL vl255_beats: got %0d cycles, required 64", n);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL vl255_beats_left: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    n_reset       = 1'b0;
    instr_valid   = 1'b0;
    instr_op      = '0;
    instr_operand = '0;
    instr_sat     = '0;
    instr_mode    = '0;
    instr_vl      = '0;
    pe_ready      = 1'b0;
    pe_resp       = 1'b0;
    test_reset();
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    test_vs1_beats();
    test_ripple();
    test_vl_zero();
    test_stall();
    test_reset_mid();
    test_vl_max();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
